// File: rtl/arp_pkg.sv
// Shared types and constants for the ARP payload extractor.
// Fixed ARP/Ethernet/IPv4 header values, field lengths and the FSM state encoding.
package arp_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    BODY = 3'd2,
    DONE = 3'd3,
    SKIP = 3'd4
  } arp_state_e;

  localparam logic [15:0] HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  HLEN_MAC   = 8'd6;
  localparam logic [7:0]  PLEN_IP    = 8'd4;
  localparam logic [15:0] OPER_REQ   = 16'd1;
  localparam logic [15:0] OPER_REP   = 16'd2;

  localparam int MAC_LEN = 6;
  localparam int IP_LEN  = 4;

  // Per-byte check of the 8-byte fixed header; idx is the header offset.
  function automatic logic hdr_byte_ok(input logic [2:0] idx, input logic [7:0] b);
    logic ok;
    case (idx)
      3'd0:    ok = (b == HTYPE_ETH[15:8]);
      3'd1:    ok = (b == HTYPE_ETH[7:0]);
      3'd2:    ok = (b == PTYPE_IPV4[15:8]);
      3'd3:    ok = (b == PTYPE_IPV4[7:0]);
      3'd4:    ok = (b == HLEN_MAC);
      3'd5:    ok = (b == PLEN_IP);
      3'd6:    ok = (b == OPER_REQ[15:8]);
      3'd7:    ok = (b == OPER_REQ[7:0]) || (b == OPER_REP[7:0]);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/arp_field_window.sv
// Offset-window decoder: raises wren while off lies in [OFF, OFF+LEN-1] and en is set.
module arp_field_window #(
  parameter int OFF   = 8,
  parameter int LEN   = 6,
  parameter int CNT_W = 6
) (
  input  logic [CNT_W-1:0] off,
  input  logic             en,
  output logic             wren
);

  localparam logic [CNT_W-1:0] LO = CNT_W'(OFF);
  localparam logic [CNT_W-1:0] HI = CNT_W'(OFF + LEN - 1);

  assign wren = en && (off >= LO) && (off <= HI);

endmodule

// File: rtl/arp_field_extractor.sv
// Byte-serial ARP payload parser: header validation, field strobes and SHA/SPA/TPA/OPER capture.
// Optional macro ARP_TPA_FILTER_EN enables the TPA == my_ip comparison for for_us.
module arp_field_extractor
  import arp_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int SHA_OFF = 8,
  parameter int SPA_OFF = 14,
  parameter int THA_OFF = 18,
  parameter int TPA_OFF = 24,
  parameter int ARP_LEN = 28
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             sclr,
  input  logic             data_en,
  input  logic [7:0]       data,
  input  logic [31:0]      my_ip,
  output logic [7:0]       byte_q,
  output logic [CNT_W-1:0] off_q,
  output logic             sha_wren,
  output logic             spa_wren,
  output logic             tha_wren,
  output logic             tpa_wren,
  output logic [47:0]      sender_mac,
  output logic [31:0]      sender_ip,
  output logic [31:0]      target_ip,
  output logic [15:0]      opcode,
  output logic             arp_valid,
  output logic             is_request,
  output logic             for_us,
  output logic             arp_err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] OP_LO    = CNT_W'(6);
  localparam logic [CNT_W-1:0] LAST_OFF = CNT_W'(ARP_LEN - 1);
  localparam logic [CNT_W-1:0] SHA_LO   = CNT_W'(SHA_OFF);
  localparam logic [CNT_W-1:0] SHA_HI   = CNT_W'(SHA_OFF + MAC_LEN - 1);
  localparam logic [CNT_W-1:0] SPA_LO   = CNT_W'(SPA_OFF);
  localparam logic [CNT_W-1:0] SPA_HI   = CNT_W'(SPA_OFF + IP_LEN - 1);
  localparam logic [CNT_W-1:0] TPA_LO   = CNT_W'(TPA_OFF);
  localparam logic [CNT_W-1:0] TPA_HI   = CNT_W'(TPA_OFF + IP_LEN - 1);

  arp_state_e       state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s, cur_off_s;
  logic             bad_r, bad_nx_s, hdr_ok_s;
  logic             valid_nx_s, err_nx_s, fld_en_r, match_s;
  logic [47:0]      sha_w_r, sha_nx_s;
  logic [31:0]      spa_w_r, spa_nx_s, tpa_w_r, tpa_nx_s;
  logic [15:0]      op_w_r, op_nx_s;

  // Offset of the byte currently on data; a new frame always starts at 0 from IDLE.
  always_comb begin
    cur_off_s = cnt_r;
    if (state_r == IDLE) begin
      cur_off_s = CNT_ZERO;
    end else begin
      cur_off_s = cnt_r;
    end
  end

  // Saturating byte counter, cleared between frames so padding can never wrap onto a field.
  always_comb begin
    cnt_nx_s = CNT_ZERO;
    if (!data_en) begin
      cnt_nx_s = CNT_ZERO;
    end else if (cur_off_s == CNT_MAX) begin
      cnt_nx_s = CNT_MAX;
    end else begin
      cnt_nx_s = cur_off_s + CNT_ONE;
    end
  end

  assign hdr_ok_s = hdr_byte_ok(cur_off_s[2:0], data);

  // Next-state logic with the valid/error pulse decisions.
  always_comb begin
    state_nx_s = state_r;
    bad_nx_s   = bad_r;
    valid_nx_s = 1'b0;
    err_nx_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (data_en) begin
          state_nx_s = HDR;
          bad_nx_s   = !hdr_ok_s;
        end else begin
          state_nx_s = IDLE;
          bad_nx_s   = 1'b0;
        end
      end
      HDR: begin
        if (!data_en) begin
          state_nx_s = IDLE;
          err_nx_s   = 1'b1;
        end else begin
          bad_nx_s = bad_r || !hdr_ok_s;
          if (cur_off_s != HDR_LAST) begin
            state_nx_s = HDR;
          end else if (bad_nx_s) begin
            state_nx_s = SKIP;
            err_nx_s   = 1'b1;
          end else begin
            state_nx_s = BODY;
          end
        end
      end
      BODY: begin
        if (!data_en) begin
          state_nx_s = IDLE;
          err_nx_s   = 1'b1;
        end else if (cur_off_s == LAST_OFF) begin
          state_nx_s = DONE;
          valid_nx_s = 1'b1;
        end else begin
          state_nx_s = BODY;
        end
      end
      DONE, SKIP: begin
        if (!data_en) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
        bad_nx_s   = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_r <= IDLE;
    end else if (sclr) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Working field shifters; MSB arrives first so each byte shifts in at the bottom.
  always_comb begin
    sha_nx_s = sha_w_r;
    spa_nx_s = spa_w_r;
    tpa_nx_s = tpa_w_r;
    op_nx_s  = op_w_r;
    if (data_en && (state_r == HDR) && (cur_off_s >= OP_LO) && (cur_off_s <= HDR_LAST)) begin
      op_nx_s = {op_w_r[7:0], data};
    end else begin
      op_nx_s = op_w_r;
    end
    if (data_en && (state_r == BODY)) begin
      if ((cur_off_s >= SHA_LO) && (cur_off_s <= SHA_HI)) begin
        sha_nx_s = {sha_w_r[39:0], data};
      end else begin
        sha_nx_s = sha_w_r;
      end
      if ((cur_off_s >= SPA_LO) && (cur_off_s <= SPA_HI)) begin
        spa_nx_s = {spa_w_r[23:0], data};
      end else begin
        spa_nx_s = spa_w_r;
      end
      if ((cur_off_s >= TPA_LO) && (cur_off_s <= TPA_HI)) begin
        tpa_nx_s = {tpa_w_r[23:0], data};
      end else begin
        tpa_nx_s = tpa_w_r;
      end
    end else begin
      sha_nx_s = sha_w_r;
      spa_nx_s = spa_w_r;
      tpa_nx_s = tpa_w_r;
    end
  end

`ifdef ARP_TPA_FILTER_EN
  assign match_s = (tpa_nx_s == my_ip);
`else
  logic unused_s;
  assign unused_s = ^my_ip;
  assign match_s  = 1'b1;
`endif

  // Byte pipeline, counter and working registers.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt_r    <= CNT_ZERO;
      bad_r    <= 1'b0;
      byte_q   <= 8'h00;
      off_q    <= CNT_ZERO;
      fld_en_r <= 1'b0;
      sha_w_r  <= 48'h0;
      spa_w_r  <= 32'h0;
      tpa_w_r  <= 32'h0;
      op_w_r   <= 16'h0;
    end else if (sclr) begin
      cnt_r    <= CNT_ZERO;
      bad_r    <= 1'b0;
      byte_q   <= 8'h00;
      off_q    <= CNT_ZERO;
      fld_en_r <= 1'b0;
      sha_w_r  <= 48'h0;
      spa_w_r  <= 32'h0;
      tpa_w_r  <= 32'h0;
      op_w_r   <= 16'h0;
    end else begin
      cnt_r    <= cnt_nx_s;
      bad_r    <= bad_nx_s;
      byte_q   <= data;
      off_q    <= data_en ? cur_off_s : CNT_ZERO;
      fld_en_r <= data_en && ((state_r == IDLE) || (state_r == HDR) || (state_r == BODY));
      sha_w_r  <= sha_nx_s;
      spa_w_r  <= spa_nx_s;
      tpa_w_r  <= tpa_nx_s;
      op_w_r   <= op_nx_s;
    end
  end

  // Result registers: pulses every cycle, captured fields only on a complete frame.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      arp_valid  <= 1'b0;
      arp_err    <= 1'b0;
      is_request <= 1'b0;
      for_us     <= 1'b0;
      sender_mac <= 48'h0;
      sender_ip  <= 32'h0;
      target_ip  <= 32'h0;
      opcode     <= 16'h0;
    end else if (sclr) begin
      arp_valid  <= 1'b0;
      arp_err    <= 1'b0;
      is_request <= 1'b0;
      for_us     <= 1'b0;
      sender_mac <= 48'h0;
      sender_ip  <= 32'h0;
      target_ip  <= 32'h0;
      opcode     <= 16'h0;
    end else begin
      arp_valid  <= valid_nx_s;
      arp_err    <= err_nx_s;
      is_request <= valid_nx_s && (op_nx_s == OPER_REQ);
      for_us     <= valid_nx_s && match_s;
      if (valid_nx_s) begin
        sender_mac <= sha_nx_s;
        sender_ip  <= spa_nx_s;
        target_ip  <= tpa_nx_s;
        opcode     <= op_nx_s;
      end else begin
        sender_mac <= sender_mac;
        sender_ip  <= sender_ip;
        target_ip  <= target_ip;
        opcode     <= opcode;
      end
    end
  end

  arp_field_window #(.OFF(SHA_OFF), .LEN(MAC_LEN), .CNT_W(CNT_W)) u_sha_win (
    .off(off_q), .en(fld_en_r), .wren(sha_wren)
  );
  arp_field_window #(.OFF(SPA_OFF), .LEN(IP_LEN), .CNT_W(CNT_W)) u_spa_win (
    .off(off_q), .en(fld_en_r), .wren(spa_wren)
  );
  arp_field_window #(.OFF(THA_OFF), .LEN(MAC_LEN), .CNT_W(CNT_W)) u_tha_win (
    .off(off_q), .en(fld_en_r), .wren(tha_wren)
  );
  arp_field_window #(.OFF(TPA_OFF), .LEN(IP_LEN), .CNT_W(CNT_W)) u_tpa_win (
    .off(off_q), .en(fld_en_r), .wren(tpa_wren)
  );

endmodule

// File: tb/tb_arp_field_extractor.sv
// Directed self-checking bench for arp_field_extractor with hand-computed expectations.
module tb_arp_field_extractor;

  logic        clock = 1'b0;
  logic        aclr_n, sclr, data_en;
  logic [7:0]  data;
  logic [31:0] my_ip;
  logic [7:0]  byte_q;
  logic [5:0]  off_q;
  logic        sha_wren, spa_wren, tha_wren, tpa_wren;
  logic [47:0] sender_mac;
  logic [31:0] sender_ip, target_ip;
  logic [15:0] opcode;
  logic        arp_valid, is_request, for_us, arp_err;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [7:0]  frm [0:79];
  logic [3:0]  stb_exp;
  logic        for_us_exp;

  arp_field_extractor dut (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .data_en(data_en), .data(data),
    .my_ip(my_ip), .byte_q(byte_q), .off_q(off_q),
    .sha_wren(sha_wren), .spa_wren(spa_wren), .tha_wren(tha_wren), .tpa_wren(tpa_wren),
    .sender_mac(sender_mac), .sender_ip(sender_ip), .target_ip(target_ip), .opcode(opcode),
    .arp_valid(arp_valid), .is_request(is_request), .for_us(for_us), .arp_err(arp_err)
  );

  always #5 clock = ~clock;

  task automatic step(input logic en, input logic [7:0] b);
    data_en = en;
    data    = b;
    @(posedge clock);
    #1;
  endtask

  task automatic build_frame(input logic [15:0] ptype, input logic [15:0] oper,
                             input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
    for (int k = 0; k < 80; k++) frm[k] = 8'h00;
    frm[0] = 8'h00; frm[1] = 8'h01; frm[2] = ptype[15:8]; frm[3] = ptype[7:0];
    frm[4] = 8'h06; frm[5] = 8'h04; frm[6] = oper[15:8];  frm[7] = oper[7:0];
    for (int k = 0; k < 6; k++) frm[8 + k]  = sha[47 - 8 * k -: 8];
    for (int k = 0; k < 4; k++) frm[14 + k] = spa[31 - 8 * k -: 8];
    for (int k = 0; k < 6; k++) frm[18 + k] = 8'hA0 + 8'(k);
    for (int k = 0; k < 4; k++) frm[24 + k] = tpa[31 - 8 * k -: 8];
  endtask

  task automatic test_reset();
    aclr_n = 1'b0; sclr = 1'b0; data_en = 1'b0; data = 8'h00; my_ip = 32'hC0A80102;
    repeat (3) @(posedge clock);
    #1;
    vec_cnt++;
    if ({arp_valid, arp_err, is_request, for_us, sha_wren, spa_wren, tha_wren, tpa_wren} !== 8'h00) begin
      err_cnt++; $display("FAIL reset_flags: got %b want 00000000",
        {arp_valid, arp_err, is_request, for_us, sha_wren, spa_wren, tha_wren, tpa_wren});
    end
    vec_cnt++;
    if ({sender_mac, sender_ip, target_ip, opcode} !== 128'h0) begin
      err_cnt++; $display("FAIL reset_fields: got %h want 0", {sender_mac, sender_ip, target_ip, opcode});
    end
    vec_cnt++;
    if ({byte_q, off_q} !== 14'h0) begin
      err_cnt++; $display("FAIL reset_pipe: got %h/%h want 0/0", byte_q, off_q);
    end
    aclr_n = 1'b1;
    step(1'b0, 8'h00);
  endtask

  task automatic test_request();
    build_frame(16'h0800, 16'd1, 48'h021122334455, 32'hC0A8010A, 32'hC0A80102);
    for (int i = 0; i < 28; i++) begin
      step(1'b1, frm[i]);
      stb_exp = {(i >= 8 && i <= 13), (i >= 14 && i <= 17), (i >= 18 && i <= 23), (i >= 24 && i <= 27)};
      vec_cnt++;
      if ({sha_wren, spa_wren, tha_wren, tpa_wren} !== stb_exp) begin
        err_cnt++; $display("FAIL req_strobes off %0d: got %b want %b", i,
          {sha_wren, spa_wren, tha_wren, tpa_wren}, stb_exp);
      end
      vec_cnt++;
      if (off_q !== i[5:0] || byte_q !== frm[i]) begin
        err_cnt++; $display("FAIL req_pipe off %0d: got %0d/%h want %0d/%h", i, off_q, byte_q, i, frm[i]);
      end
      vec_cnt++;
      if (arp_valid !== (i == 27) || arp_err !== 1'b0) begin
        err_cnt++; $display("FAIL req_pulse off %0d: got v%b e%b want v%b e0", i, arp_valid, arp_err, i == 27);
      end
    end
    vec_cnt++;
    if (is_request !== 1'b1 || for_us !== 1'b1) begin
      err_cnt++; $display("FAIL req_flags: got req%b us%b want req1 us1", is_request, for_us);
    end
    vec_cnt++;
    if (sender_ip !== 32'hC0A8010A || target_ip !== 32'hC0A80102) begin
      err_cnt++; $display("FAIL req_ips: got %h/%h want c0a8010a/c0a80102", sender_ip, target_ip);
    end
    vec_cnt++;
    if (sender_mac !== 48'h021122334455 || opcode !== 16'h0001) begin
      err_cnt++; $display("FAIL req_mac_op: got %h/%h want 021122334455/0001", sender_mac, opcode);
    end
    step(1'b0, 8'h00);
    vec_cnt++;
    if (arp_valid !== 1'b0 || is_request !== 1'b0) begin
      err_cnt++; $display("FAIL req_pulse_end: got v%b r%b want v0 r0", arp_valid, is_request);
    end
  endtask

  task automatic test_reply();
`ifdef ARP_TPA_FILTER_EN
    for_us_exp = 1'b0;
`else
    for_us_exp = 1'b1;
`endif
    build_frame(16'h0800, 16'd2, 48'hAABBCCDDEEFF, 32'hC0A80105, 32'hC0A80163);
    for (int i = 0; i < 28; i++) step(1'b1, frm[i]);
    vec_cnt++;
    if (arp_valid !== 1'b1 || is_request !== 1'b0 || for_us !== for_us_exp) begin
      err_cnt++; $display("FAIL rep_flags: got v%b r%b us%b want v1 r0 us%b", arp_valid, is_request, for_us, for_us_exp);
    end
    vec_cnt++;
    if (opcode !== 16'h0002 || target_ip !== 32'hC0A80163 || sender_mac !== 48'hAABBCCDDEEFF) begin
      err_cnt++; $display("FAIL rep_fields: got %h/%h/%h want 0002/c0a80163/aabbccddeeff", opcode, target_ip, sender_mac);
    end
    step(1'b0, 8'h00);
  endtask

  task automatic test_bad_ptype();
    build_frame(16'h86DD, 16'd1, 48'h111111111111, 32'h0A000001, 32'hC0A80102);
    for (int i = 0; i < 28; i++) begin
      step(1'b1, frm[i]);
      vec_cnt++;
      if (arp_err !== (i == 7) || arp_valid !== 1'b0) begin
        err_cnt++; $display("FAIL bad_pulse off %0d: got e%b v%b want e%b v0", i, arp_err, arp_valid, i == 7);
      end
      vec_cnt++;
      if ({sha_wren, spa_wren, tha_wren, tpa_wren} !== 4'b0000) begin
        err_cnt++; $display("FAIL bad_strobes off %0d: got %b want 0000", i, {sha_wren, spa_wren, tha_wren, tpa_wren});
      end
    end
    step(1'b0, 8'h00);
    vec_cnt++;
    if (sender_ip !== 32'hC0A80105 || opcode !== 16'h0002 || sender_mac !== 48'hAABBCCDDEEFF || arp_err !== 1'b0) begin
      err_cnt++; $display("FAIL bad_hold: got %h/%h/%h e%b want c0a80105/0002/aabbccddeeff e0",
        sender_ip, opcode, sender_mac, arp_err);
    end
  endtask

  task automatic test_truncate();
    build_frame(16'h0800, 16'd1, 48'h222222222222, 32'h0A0A0A0A, 32'hC0A80102);
    for (int i = 0; i < 20; i++) step(1'b1, frm[i]);
    step(1'b0, 8'h00);
    vec_cnt++;
    if (arp_err !== 1'b1 || arp_valid !== 1'b0) begin
      err_cnt++; $display("FAIL trunc_pulse: got e%b v%b want e1 v0", arp_err, arp_valid);
    end
    vec_cnt++;
    if (sender_ip !== 32'hC0A80105 || sender_mac !== 48'hAABBCCDDEEFF) begin
      err_cnt++; $display("FAIL trunc_hold: got %h/%h want c0a80105/aabbccddeeff", sender_ip, sender_mac);
    end
    build_frame(16'h0800, 16'd1, 48'h333333333333, 32'h0A0B0C0D, 32'hC0A80102);
    for (int i = 0; i < 28; i++) begin
      step(1'b1, frm[i]);
      vec_cnt++;
      if (arp_err !== 1'b0 || arp_valid !== (i == 27)) begin
        err_cnt++; $display("FAIL b2b_pulse off %0d: got e%b v%b want e0 v%b", i, arp_err, arp_valid, i == 27);
      end
    end
    vec_cnt++;
    if (sender_ip !== 32'h0A0B0C0D || sender_mac !== 48'h333333333333) begin
      err_cnt++; $display("FAIL b2b_fields: got %h/%h want 0a0b0c0d/333333333333", sender_ip, sender_mac);
    end
    step(1'b0, 8'h00);
  endtask

  // Covers both the 46-byte padded frame and a long frame that drives the counter into saturation.
  task automatic test_padding(input int len);
    int nvalid;
    nvalid = 0;
    build_frame(16'h0800, 16'd2, 48'h444444444444, 32'h01020304, 32'hC0A80102);
    for (int i = 0; i < len; i++) begin
      step(1'b1, frm[i]);
      if (arp_valid === 1'b1) nvalid++;
      if (i >= 28) begin
        vec_cnt++;
        if ({sha_wren, spa_wren, tha_wren, tpa_wren} !== 4'b0000 || arp_err !== 1'b0) begin
          err_cnt++; $display("FAIL pad_strobes off %0d: got %b e%b want 0000 e0", i,
            {sha_wren, spa_wren, tha_wren, tpa_wren}, arp_err);
        end
        vec_cnt++;
        if (off_q !== ((i > 63) ? 6'd63 : i[5:0])) begin
          err_cnt++; $display("FAIL pad_offset byte %0d: got %0d want %0d", i, off_q, (i > 63) ? 63 : i);
        end
      end
    end
    step(1'b0, 8'h00);
    vec_cnt++;
    if (nvalid != 1 || sender_ip !== 32'h01020304) begin
      err_cnt++; $display("FAIL pad_valid len %0d: got %0d pulses ip %h want 1 pulse ip 01020304", len, nvalid, sender_ip);
    end
  endtask

  task automatic test_sclr();
    build_frame(16'h0800, 16'd1, 48'h555555555555, 32'h05050505, 32'hC0A80102);
    for (int i = 0; i < 10; i++) step(1'b1, frm[i]);
    sclr = 1'b1;
    step(1'b1, frm[10]);
    vec_cnt++;
    if ({sender_mac, sender_ip, target_ip, opcode} !== 128'h0 || off_q !== 6'd0 || byte_q !== 8'h00) begin
      err_cnt++; $display("FAIL sclr_clear: got %h off %0d byte %h want 0", {sender_ip, opcode}, off_q, byte_q);
    end
    sclr = 1'b0;
    step(1'b0, 8'h00);
    for (int i = 0; i < 28; i++) step(1'b1, frm[i]);
    vec_cnt++;
    if (arp_valid !== 1'b1 || sender_ip !== 32'h05050505 || opcode !== 16'h0001) begin
      err_cnt++; $display("FAIL sclr_after: got v%b %h/%h want v1 05050505/0001", arp_valid, sender_ip, opcode);
    end
    step(1'b0, 8'h00);
  endtask

  task automatic test_aclr_mid();
    build_frame(16'h0800, 16'd1, 48'h666666666666, 32'hC0A80177, 32'hC0A80102);
    for (int i = 0; i < 17; i++) step(1'b1, frm[i]);
    data_en = 1'b0;
    aclr_n  = 1'b0;
    #2;
    vec_cnt++;
    if ({sender_mac, sender_ip, target_ip, opcode} !== 128'h0 || {byte_q, off_q} !== 14'h0) begin
      err_cnt++; $display("FAIL aclr_fields: got %h/%h want 0", sender_ip, opcode);
    end
    @(posedge clock);
    #1;
    vec_cnt++;
    if ({arp_valid, arp_err, is_request, for_us, sha_wren, spa_wren, tha_wren, tpa_wren} !== 8'h00) begin
      err_cnt++; $display("FAIL aclr_flags: got %b want 00000000",
        {arp_valid, arp_err, is_request, for_us, sha_wren, spa_wren, tha_wren, tpa_wren});
    end
    aclr_n = 1'b1;
    step(1'b0, 8'h00);
    for (int i = 0; i < 28; i++) begin
      step(1'b1, frm[i]);
      vec_cnt++;
      if (arp_err !== 1'b0 || arp_valid !== (i == 27)) begin
        err_cnt++; $display("FAIL aclr_frame off %0d: got e%b v%b want e0 v%b", i, arp_err, arp_valid, i == 27);
      end
    end
    vec_cnt++;
    if (sender_ip !== 32'hC0A80177 || is_request !== 1'b1 || for_us !== 1'b1) begin
      err_cnt++; $display("FAIL aclr_result: got %h r%b us%b want c0a80177 r1 us1", sender_ip, is_request, for_us);
    end
    step(1'b0, 8'h00);
    vec_cnt++;
    if (arp_err !== 1'b0 || arp_valid !== 1'b0) begin
      err_cnt++; $display("FAIL aclr_tail: got e%b v%b want e0 v0", arp_err, arp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_request();
    test_reply();
    test_bad_ptype();
    test_truncate();
    test_padding(46);
    test_padding(70);
    test_sclr();
    test_aclr_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
